// File: rtl/branch_repair_issuer_pkg.sv
// Shared action codes, widths and helpers for the branch repair issuer.
package branch_repair_issuer_pkg;

  localparam int REPAIR_ACTION  = 2;
  localparam int ALL_CHECKPOINT = 16;

  localparam logic [1:0] REPAIR_NONE  = 2'd0;
  localparam logic [1:0] REPAIR_TRAIN = 2'd1;
  localparam logic [1:0] REPAIR_TAKE  = 2'd2;
  localparam logic [1:0] REPAIR_DEST  = 2'd3;

  localparam logic [31:0] DELAY_SLOT_OFF = 32'd8;

  typedef enum logic {
    NORMAL,
    SQUASH
  } state_t;

  // Not-taken/not-taken agrees regardless of the target fields.
  function automatic logic [1:0] classify(
    input logic        pred_take,
    input logic [31:0] pred_dest,
    input logic        real_take,
    input logic [31:0] real_dest
  );
    logic [1:0] act;
    act = REPAIR_TRAIN;
    if (pred_take != real_take)
      act = REPAIR_TAKE;
    else if (real_take && (pred_dest != real_dest))
      act = REPAIR_DEST;
    return act;
  endfunction

endpackage

// File: rtl/branch_repair_issuer_fifo.sv
// Generic synchronous FIFO with flush for queued repair actions.
module repair_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign dout    = mem[rd_ptr];
  // A slot freed by a pop only becomes writable next cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push)
                 - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/branch_repair_issuer.sv
// Compares resolved branches with predictions and issues repairs/redirects.
// Optional perf counters enabled by defining BRU_PERF_STATS_EN.
module branch_repair_issuer
  import branch_repair_issuer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int CKPT_W = ALL_CHECKPOINT,
  parameter int ACT_W  = REPAIR_ACTION
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid_i,
  output logic              res_ready_o,
  input  logic [31:0]       res_vaddr_i,
  input  logic              res_predTake_i,
  input  logic [31:0]       res_predDest_i,
  input  logic              res_realTake_i,
  input  logic [31:0]       res_realDest_i,
  input  logic [CKPT_W-1:0] res_checkPoint_i,
  input  logic              repair_stall_i,
  input  logic              flush_i,
  input  logic              flush_done_i,
  output logic [ACT_W-1:0]  FU_repairAction_w_o,
  output logic [CKPT_W-1:0] FU_allCheckPoint_w_o,
  output logic [31:0]       FU_erroVAddr_w_o,
  output logic              FU_correctTake_w_o,
  output logic [31:0]       FU_correctDest_w_o,
  output logic              redirect_valid_o,
  output logic [31:0]       redirect_vaddr_o
`ifdef BRU_PERF_STATS_EN
  ,
  output logic [31:0]       perf_resolve_o,
  output logic [31:0]       perf_mispred_o
`endif
);

  localparam int EW = ACT_W + CKPT_W + 65;

  state_t          state;
  state_t          state_n;
  logic [1:0]      cls;
  logic            mis;
  logic            accept;
  logic            push;
  logic            bypass;
  logic            pop;
  logic            full;
  logic            empty;
  logic [EW-1:0]   entry;
  logic [EW-1:0]   head;
  logic [31:0]     target;

  assign cls = classify(res_predTake_i, res_predDest_i,
                        res_realTake_i, res_realDest_i);
  assign mis = (cls != REPAIR_TRAIN);

  assign res_ready_o = (state == SQUASH) || !full;
  assign accept = res_valid_i && res_ready_o && !flush_i;
  assign push   = accept && (state == NORMAL);
  // Empty queue and free bus: go straight to the bus for 1-cycle latency.
  assign bypass = push && empty && !repair_stall_i;
  assign pop    = !empty && !repair_stall_i && !flush_i;

  assign entry = {ACT_W'(cls), res_checkPoint_i, res_vaddr_i,
                  res_realTake_i, res_realDest_i};

  assign target = res_realTake_i ? res_realDest_i
                                 : res_vaddr_i + DELAY_SLOT_OFF;

  repair_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_i),
    .push  (push && !bypass),
    .din   (entry),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      FU_repairAction_w_o  <= '0;
      FU_allCheckPoint_w_o <= '0;
      FU_erroVAddr_w_o     <= '0;
      FU_correctTake_w_o   <= 1'b0;
      FU_correctDest_w_o   <= '0;
    end else if (bypass) begin
      {FU_repairAction_w_o, FU_allCheckPoint_w_o,
       FU_erroVAddr_w_o, FU_correctTake_w_o,
       FU_correctDest_w_o} <= entry;
    end else if (pop) begin
      {FU_repairAction_w_o, FU_allCheckPoint_w_o,
       FU_erroVAddr_w_o, FU_correctTake_w_o,
       FU_correctDest_w_o} <= head;
    end else begin
      FU_repairAction_w_o <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid_o <= 1'b0;
      redirect_vaddr_o <= '0;
    end else begin
      redirect_valid_o <= push && mis;
      if (push && mis) redirect_vaddr_o <= target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= NORMAL;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush_i) begin
      state_n = NORMAL;
    end else begin
      case (state)
        NORMAL: if (push && mis) state_n = SQUASH;
        SQUASH: if (flush_done_i) state_n = NORMAL;
        default: state_n = NORMAL;
      endcase
    end
  end

`ifdef BRU_PERF_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_resolve_o <= '0;
      perf_mispred_o <= '0;
    end else begin
      if (push && (perf_resolve_o != '1))
        perf_resolve_o <= perf_resolve_o + 1'b1;
      if (push && mis && (perf_mispred_o != '1))
        perf_mispred_o <= perf_mispred_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_repair_issuer.sv
// Directed table-driven bench for branch_repair_issuer.
module tb_branch_repair_issuer;
  import branch_repair_issuer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_vaddr;
  logic        res_pt;
  logic [31:0] res_pd;
  logic        res_rt;
  logic [31:0] res_rd;
  logic [15:0] res_ck;
  logic        stall;
  logic        flush;
  logic        flush_done;
  logic [1:0]  fu_act;
  logic [15:0] fu_ck;
  logic [31:0] fu_va;
  logic        fu_take;
  logic [31:0] fu_dest;
  logic        rd_valid;
  logic [31:0] rd_vaddr;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  branch_repair_issuer dut (
    .clk                  (clk),
    .rst                  (rst),
    .res_valid_i          (res_valid),
    .res_ready_o          (res_ready),
    .res_vaddr_i          (res_vaddr),
    .res_predTake_i       (res_pt),
    .res_predDest_i       (res_pd),
    .res_realTake_i       (res_rt),
    .res_realDest_i       (res_rd),
    .res_checkPoint_i     (res_ck),
    .repair_stall_i       (stall),
    .flush_i              (flush),
    .flush_done_i         (flush_done),
    .FU_repairAction_w_o  (fu_act),
    .FU_allCheckPoint_w_o (fu_ck),
    .FU_erroVAddr_w_o     (fu_va),
    .FU_correctTake_w_o   (fu_take),
    .FU_correctDest_w_o   (fu_dest),
    .redirect_valid_o     (rd_valid),
    .redirect_vaddr_o     (rd_vaddr)
  );

  typedef struct {
    logic [31:0] va;
    logic        pt;
    logic [31:0] pd;
    logic        rt;
    logic [31:0] rd;
    logic [15:0] ck;
    logic [1:0]  act;
    logic        redir;
    logic [31:0] rva;
  } vec_t;

  vec_t v[7];

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] va,
                       input logic pt, input logic [31:0] pd,
                       input logic rt, input logic [31:0] rd,
                       input logic [15:0] ck);
    res_valid = 1'b1;
    res_vaddr = va;
    res_pt    = pt;
    res_pd    = pd;
    res_rt    = rt;
    res_rd    = rd;
    res_ck    = ck;
  endtask

  initial begin
    int k;
    int got;
    int first;
    int last;
    logic r;

    v[0] = '{32'h8000_0000, 1, 32'h8000_0100, 1, 32'h8000_0100,
             16'h0001, REPAIR_TRAIN, 0, 32'h0};
    v[1] = '{32'hBFC0_0010, 1, 32'h0000_0100, 1, 32'h0000_0200,
             16'h0002, REPAIR_DEST, 1, 32'h0000_0200};
    v[2] = '{32'hBFC0_0FFC, 1, 32'h0000_0300, 0, 32'h0000_1234,
             16'h0003, REPAIR_TAKE, 1, 32'hBFC0_1004};
    v[3] = '{32'hFFFF_FFFC, 1, 32'h0000_0040, 0, 32'h0000_0050,
             16'h0004, REPAIR_TAKE, 1, 32'h0000_0004};
    v[4] = '{32'h0000_2000, 0, 32'h0000_0010, 0, 32'h0000_0020,
             16'h0005, REPAIR_TRAIN, 0, 32'h0};
    v[5] = '{32'h0000_3000, 0, 32'h0000_0000, 1, 32'h0000_0400,
             16'h0006, REPAIR_TAKE, 1, 32'h0000_0400};
    v[6] = '{32'h0000_1000, 1, 32'h0000_0800, 1, 32'h0000_0800,
             16'hBEEF, REPAIR_TRAIN, 0, 32'h0};

    rst = 1; res_valid = 0; res_vaddr = 0; res_pt = 0; res_pd = 0;
    res_rt = 0; res_rd = 0; res_ck = 0; stall = 0; flush = 0;
    flush_done = 0;
    tick; tick;
    rst = 0;
    chk("rst_act", 32'(fu_act), 0);
    chk("rst_ck", 32'(fu_ck), 0);
    chk("rst_va", fu_va, 0);
    chk("rst_take", 32'(fu_take), 0);
    chk("rst_dest", fu_dest, 0);
    chk("rst_rv", 32'(rd_valid), 0);
    chk("rst_rva", rd_vaddr, 0);
    chk("rst_ready", 32'(res_ready), 1);

    for (int i = 0; i < 7; i++) begin
      drive(v[i].va, v[i].pt, v[i].pd, v[i].rt, v[i].rd, v[i].ck);
      chk($sformatf("v%0d_ready", i), 32'(res_ready), 1);
      tick;
      res_valid = 0;
      chk($sformatf("v%0d_act", i), 32'(fu_act), 32'(v[i].act));
      chk($sformatf("v%0d_va", i), fu_va, v[i].va);
      chk($sformatf("v%0d_take", i), 32'(fu_take), 32'(v[i].rt));
      chk($sformatf("v%0d_dest", i), fu_dest, v[i].rd);
      chk($sformatf("v%0d_ck", i), 32'(fu_ck), 32'(v[i].ck));
      chk($sformatf("v%0d_rv", i), 32'(rd_valid), 32'(v[i].redir));
      if (v[i].redir)
        chk($sformatf("v%0d_rva", i), rd_vaddr, v[i].rva);
      tick;
      chk($sformatf("v%0d_rv_pulse", i), 32'(rd_valid), 0);
      chk($sformatf("v%0d_act_idle", i), 32'(fu_act), 0);
      if (v[i].redir) begin
        flush_done = 1;
        tick;
        flush_done = 0;
      end
    end

    // Wrong-path resolutions are dropped while squashing.
    drive(32'hBFC0_0010, 1, 32'h100, 1, 32'h200, 16'h0010);
    tick;
    chk("sq_act", 32'(fu_act), 32'(REPAIR_DEST));
    chk("sq_rva", rd_vaddr, 32'h200);
    for (int c = 0; c < 2; c++) begin
      drive(32'h1111_0000 + 32'(c), 1, 32'h40, 1, 32'h40, 16'h0);
      chk("sq_ready", 32'(res_ready), 1);
      tick;
      chk("sq_drop", 32'(fu_act), 0);
      chk("sq_norv", 32'(rd_valid), 0);
    end
    res_valid = 0;
    flush_done = 1;
    tick;
    flush_done = 0;
    drive(32'h2222_0000, 1, 32'h40, 1, 32'h40, 16'h0);
    tick;
    res_valid = 0;
    chk("sq_resume_act", 32'(fu_act), 32'(REPAIR_TRAIN));
    chk("sq_resume_va", fu_va, 32'h2222_0000);
    tick;

    // Stall: four slots fill, fifth waits, then five drain in order.
    stall = 1;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      res_valid = (k < 5);
      res_vaddr = 32'h3000_0000 + 32'(k * 4);
      res_pt = 1; res_pd = 32'h40; res_rt = 1; res_rd = 32'h40;
      chk("st_ready", 32'(res_ready), 32'(k < 4));
      chk("st_bus", 32'(fu_act), 0);
      r = res_ready;
      tick;
      if (r && res_valid) k++;
    end
    chk("st_accepts", 32'(k), 4);
    stall = 0;
    got = 0;
    first = -1;
    last = -1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      res_valid = (k < 5);
      res_vaddr = 32'h3000_0000 + 32'(k * 4);
      r = res_ready;
      tick;
      if (r && res_valid) k++;
      if (fu_act != 0) begin
        chk("st_order", fu_va, 32'h3000_0000 + 32'(got * 4));
        chk("st_kind", 32'(fu_act), 32'(REPAIR_TRAIN));
        if (first < 0) first = c;
        last = c;
        got++;
      end
    end
    res_valid = 0;
    chk("st_drained", 32'(got), 5);
    chk("st_b2b", 32'(last - first), 4);
    tick;
    chk("st_idle", 32'(fu_act), 0);

    // Flush with 3 queued and a colliding mispredict.
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h5000_0000 + 32'(i * 4), 1, 32'h40, 1, 32'h40, 16'h0);
      tick;
    end
    stall = 0;
    flush = 1;
    drive(32'h5100_0000, 0, 32'h0, 1, 32'h600, 16'h0);
    chk("fl_ready", 32'(res_ready), 1);
    tick;
    flush = 0;
    res_valid = 0;
    chk("fl_act", 32'(fu_act), 0);
    chk("fl_norv", 32'(rd_valid), 0);
    tick;
    chk("fl_empty", 32'(fu_act), 0);
    chk("fl_ready2", 32'(res_ready), 1);
    drive(32'h5500_0000, 1, 32'h40, 1, 32'h40, 16'h0);
    tick;
    res_valid = 0;
    chk("fl_norm_act", 32'(fu_act), 32'(REPAIR_TRAIN));
    chk("fl_norm_va", fu_va, 32'h5500_0000);
    tick;

    // Reset while squashing with two entries queued.
    stall = 1;
    drive(32'h7000_0000, 1, 32'h40, 1, 32'h40, 16'h00AA);
    tick;
    drive(32'h7100_0000, 1, 32'h10, 1, 32'h20, 16'h00BB);
    tick;
    res_valid = 0;
    chk("rs_pre_rv", 32'(rd_valid), 1);
    rst = 1;
    tick;
    rst = 0;
    stall = 0;
    chk("rs_act", 32'(fu_act), 0);
    chk("rs_ck", 32'(fu_ck), 0);
    chk("rs_va", fu_va, 0);
    chk("rs_take", 32'(fu_take), 0);
    chk("rs_dest", fu_dest, 0);
    chk("rs_rv", 32'(rd_valid), 0);
    chk("rs_rva", rd_vaddr, 0);
    chk("rs_ready", 32'(res_ready), 1);
    tick;
    chk("rs_empty", 32'(fu_act), 0);
    chk("rs_empty_va", fu_va, 0);
    drive(32'h7700_0000, 1, 32'h40, 1, 32'h40, 16'h0);
    tick;
    res_valid = 0;
    chk("rs_norm", 32'(fu_act), 32'(REPAIR_TRAIN));
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule
